// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: owner and sequencer state encodings plus the grant picker.
package InstructionStruct;

  typedef enum logic [1:0] {OWN_NONE, OWN_DATA, OWN_FETCH, OWN_DISP} mem_owner_t;

  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_DONE} arb_state_t;

  // A starved fetch or display port overrides data priority; fetch wins when both are starved.
  function automatic mem_owner_t arb_pick(input logic dt, input logic fe, input logic ds,
                                          input logic fe_starved, input logic ds_starved);
    if (fe && fe_starved) return OWN_FETCH;
    if (ds && ds_starved) return OWN_DISP;
    if (dt) return OWN_DATA;
    if (fe) return OWN_FETCH;
    if (ds) return OWN_DISP;
    return OWN_NONE;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_age_counter.sv
// Saturating lost-arbitration counter for one low-priority port; starved is high once STARVE_MAX losses accrue.
module mem_arb_age_counter #(
  parameter int STARVE_MAX = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic lose,
  input  logic win,
  output logic starved
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] L_MAX = CW'(STARVE_MAX);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (win) begin
      r_cnt <= '0;
    end else if (lose && (r_cnt != L_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign starved = (r_cnt == L_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between data, fetch and display requesters: IDLE -> ISSUE -> MEM_LAT x WAIT -> DONE.
// Strict data > fetch > display priority unless MEM_ARB_FAIRNESS_EN is defined, which ages fetch/display losses.
module mem_port_arbiter
  import InstructionStruct::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              dt_req,
  input  logic              dt_we,
  input  logic [ADDR_W-1:0] dt_addr,
  input  logic [DATA_W-1:0] dt_wdata,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              ds_req,
  input  logic [ADDR_W-1:0] ds_addr,
  output logic              dt_gnt,
  output logic              if_gnt,
  output logic              ds_gnt,
  output logic              dt_done,
  output logic              if_done,
  output logic              ds_done,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int WW = $clog2(MEM_LAT + 1);

  arb_state_t        r_state, w_next;
  mem_owner_t        r_owner, w_pick;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_rdata;
  logic              r_we;
  logic [WW-1:0]     r_wait;
  logic              w_if_starved, w_ds_starved;

`ifdef MEM_ARB_FAIRNESS_EN
  logic w_eval;
  assign w_eval = (r_state == ARB_IDLE);

  mem_arb_age_counter #(.STARVE_MAX(STARVE_MAX)) u_if_age (
    .clk     (clk),
    .reset_n (reset_n),
    .lose    (w_eval && if_req && (w_pick != OWN_FETCH)),
    .win     (w_eval && (w_pick == OWN_FETCH)),
    .starved (w_if_starved)
  );

  mem_arb_age_counter #(.STARVE_MAX(STARVE_MAX)) u_ds_age (
    .clk     (clk),
    .reset_n (reset_n),
    .lose    (w_eval && ds_req && (w_pick != OWN_DISP)),
    .win     (w_eval && (w_pick == OWN_DISP)),
    .starved (w_ds_starved)
  );
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (STARVE_MAX > 0);
  assign w_if_starved = 1'b0;
  assign w_ds_starved = 1'b0;
`endif

  assign w_pick = arb_pick(dt_req, if_req, ds_req, w_if_starved, w_ds_starved);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ARB_IDLE:  if (w_pick != OWN_NONE) w_next = ARB_ISSUE;
      ARB_ISSUE: w_next = ARB_WAIT;
      ARB_WAIT:  if (r_wait == WW'(1)) w_next = ARB_DONE;
      ARB_DONE:  w_next = ARB_IDLE;
      default:   w_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ARB_IDLE;
      r_owner <= OWN_NONE;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_wait  <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ARB_IDLE: begin
          if (w_pick != OWN_NONE) begin
            r_owner <= w_pick;
            r_we    <= (w_pick == OWN_DATA) && dt_we;
            r_wdata <= (w_pick == OWN_DATA) ? dt_wdata : '0;
            case (w_pick)
              OWN_DATA:  r_addr <= dt_addr;
              OWN_FETCH: r_addr <= if_addr;
              default:   r_addr <= ds_addr;
            endcase
          end
        end
        ARB_ISSUE: r_wait <= WW'(MEM_LAT);
        ARB_WAIT: begin
          r_wait <= r_wait - 1'b1;
          // Memory data is valid exactly in the final wait cycle.
          if (r_wait == WW'(1)) r_rdata <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

  assign mem_en    = (r_state == ARB_ISSUE);
  assign mem_we    = mem_en && r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign busy      = (r_state != ARB_IDLE);
  assign rdata     = r_rdata;

  assign dt_gnt  = mem_en && (r_owner == OWN_DATA);
  assign if_gnt  = mem_en && (r_owner == OWN_FETCH);
  assign ds_gnt  = mem_en && (r_owner == OWN_DISP);
  assign dt_done = (r_state == ARB_DONE) && (r_owner == OWN_DATA);
  assign if_done = (r_state == ARB_DONE) && (r_owner == OWN_FETCH);
  assign ds_done = (r_state == ARB_DONE) && (r_owner == OWN_DISP);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-timing reference model, latency-accurate memory, directed plus random traffic.
module tb_mem_port_arbiter;

  localparam int LAT = 2;
`ifdef MEM_ARB_FAIRNESS_EN
  localparam int SMAX = 8;
  int af = 0, ad = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        dt_req, dt_we, if_req, ds_req;
  logic [31:0] dt_addr, dt_wdata, if_addr, ds_addr;
  logic        dt_gnt, if_gnt, ds_gnt, dt_done, if_done, ds_done;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_en, mem_we, busy;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .dt_req(dt_req), .dt_we(dt_we), .dt_addr(dt_addr), .dt_wdata(dt_wdata),
    .if_req(if_req), .if_addr(if_addr), .ds_req(ds_req), .ds_addr(ds_addr),
    .dt_gnt(dt_gnt), .if_gnt(if_gnt), .ds_gnt(ds_gnt),
    .dt_done(dt_done), .if_done(if_done), .ds_done(ds_done),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  int n_tests = 0, n_fail = 0;
  int cur = 0;
  bit auto_drop = 1'b1;

  // Memory device seen by the DUT, and the independent expectation memory used by the model.
  logic [31:0] dev_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] pend_data = '0;
  int          pend_due = -1;

  always @(negedge clk) begin
    if (mem_en) begin
      if (mem_we) dev_mem[mem_addr] = mem_wdata;
      else begin
        pend_data = dev_mem.exists(mem_addr) ? dev_mem[mem_addr] : 32'h0;
        pend_due  = cur + LAT;
      end
    end
    mem_rdata = (cur == pend_due) ? pend_data : $urandom;
  end

  // Transaction-level model: next free cycle, expected grant/done cycles and payload.
  int          m_free = 0, m_gnt = -1, m_done = -1, m_own = 0;
  logic        m_we = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;

  int          g_cyc[4], d_cyc[4], g_cnt[4], d_cnt[4], g_en[4];
  logic [31:0] d_rdata[4];
  int          en_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cur);
    end
  endtask

  task automatic model_eval();
    int w;
    bit fe_st, ds_st;
    fe_st = 1'b0;
    ds_st = 1'b0;
    if (!reset_n) begin
      m_gnt = -1; m_done = -1; m_free = cur + 1;
`ifdef MEM_ARB_FAIRNESS_EN
      af = 0; ad = 0;
`endif
      return;
    end
    if (cur >= m_free && (dt_req || if_req || ds_req)) begin
`ifdef MEM_ARB_FAIRNESS_EN
      fe_st = (af == SMAX);
      ds_st = (ad == SMAX);
`endif
      if (if_req && fe_st)      w = 2;
      else if (ds_req && ds_st) w = 3;
      else if (dt_req)          w = 1;
      else if (if_req)          w = 2;
      else                      w = 3;
`ifdef MEM_ARB_FAIRNESS_EN
      if (w == 2) af = 0; else if (if_req && af < SMAX) af++;
      if (w == 3) ad = 0; else if (ds_req && ad < SMAX) ad++;
`endif
      m_own  = w;
      m_gnt  = cur + 1;
      m_done = cur + LAT + 2;
      m_free = cur + LAT + 3;
      m_we   = (w == 1) && dt_we;
      m_addr = (w == 1) ? dt_addr : (w == 2) ? if_addr : ds_addr;
      m_wdata = dt_wdata;
      if (m_we) ref_mem[m_addr] = dt_wdata;
      else m_rdata = ref_mem.exists(m_addr) ? ref_mem[m_addr] : 32'h0;
    end
  endtask

  task automatic tick();
    bit act;
    model_eval();
    @(posedge clk);
    #1;
    cur++;
    act = (cur >= m_gnt) && (cur <= m_done);
    chk("busy", busy, act);
    chk("mem_en", mem_en, cur == m_gnt);
    chk("dt_gnt", dt_gnt, cur == m_gnt && m_own == 1);
    chk("if_gnt", if_gnt, cur == m_gnt && m_own == 2);
    chk("ds_gnt", ds_gnt, cur == m_gnt && m_own == 3);
    chk("dt_done", dt_done, cur == m_done && m_own == 1);
    chk("if_done", if_done, cur == m_done && m_own == 2);
    chk("ds_done", ds_done, cur == m_done && m_own == 3);
    if (cur == m_gnt) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_we", mem_we, m_we);
      if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
    end
    if (cur == m_done && !m_we) chk("rdata", rdata, m_rdata);
    if (mem_en) en_cnt++;
    if (dt_gnt) begin g_cyc[1] = cur; g_cnt[1]++; g_en[1] = en_cnt; end
    if (if_gnt) begin g_cyc[2] = cur; g_cnt[2]++; g_en[2] = en_cnt; end
    if (ds_gnt) begin g_cyc[3] = cur; g_cnt[3]++; g_en[3] = en_cnt; end
    if (dt_done) begin d_cyc[1] = cur; d_cnt[1]++; d_rdata[1] = rdata; if (auto_drop) dt_req = 1'b0; end
    if (if_done) begin d_cyc[2] = cur; d_cnt[2]++; d_rdata[2] = rdata; if (auto_drop) if_req = 1'b0; end
    if (ds_done) begin d_cyc[3] = cur; d_cnt[3]++; d_rdata[3] = rdata; if (auto_drop) ds_req = 1'b0; end
  endtask

  task automatic drain(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!dt_req && !if_req && !ds_req && cur >= m_free) begin ok = 1'b1; break; end
      tick();
    end
    chk("drain_done", ok, 1'b1);
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    dev_mem[a] = d;
    ref_mem[a] = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int start, en_base, act_base, dn_base;
    for (int i = 0; i < 4; i++) begin
      g_cyc[i] = -1; d_cyc[i] = -1; g_cnt[i] = 0; d_cnt[i] = 0; g_en[i] = 0; d_rdata[i] = '0;
    end
    reset_n = 1'b0; dt_req = 0; dt_we = 0; if_req = 0; ds_req = 0;
    dt_addr = '0; dt_wdata = '0; if_addr = '0; ds_addr = '0;

    // Reset state
    repeat (3) tick();
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_we", mem_we, 1'b0);
    reset_n = 1'b1;
    tick();

    // 1: single fetch
    preload(32'h40, 32'h6000_0000);
    start = cur;
    if_addr = 32'h40; if_req = 1'b1;
    drain(30);
    chk("t1_gnt_cyc", g_cyc[2] - start, 1);
    chk("t1_done_cyc", d_cyc[2] - start, LAT + 2);
    chk("t1_rdata", d_rdata[2], 32'h6000_0000);

    // 2: store and fetch together, data goes first
    start = cur;
    dt_req = 1'b1; dt_we = 1'b1; dt_addr = 32'h100; dt_wdata = 32'hDEAD_BEEF;
    if_req = 1'b1; if_addr = 32'h40;
    drain(40);
    dt_we = 1'b0;
    chk("t2_dt_gnt_cyc", g_cyc[1] - start, 1);
    chk("t2_if_gnt_cyc", g_cyc[2] - start, LAT + 4);
    chk("t2_mem_0x100", dev_mem.exists(32'h100) ? dev_mem[32'h100] : 32'h0, 32'hDEAD_BEEF);

    // 3: data and display held for 12 transactions
    g_cnt[3] = 0; en_base = en_cnt; auto_drop = 1'b0;
    dt_req = 1'b1; dt_addr = 32'h200; ds_req = 1'b1; ds_addr = 32'h300;
    repeat (12 * (LAT + 3)) tick();
    dt_req = 1'b0; ds_req = 1'b0; auto_drop = 1'b1;
    chk("t3_txn_count", en_cnt - en_base, 12);
`ifdef MEM_ARB_FAIRNESS_EN
    chk("t3_ds_gnts", g_cnt[3], 1);
    chk("t3_ds_slot", g_en[3] - en_base, 9);
`else
    chk("t3_ds_gnts", g_cnt[3], 0);
`endif
    drain(20);

    // 4: reset in the middle of a load
    preload(32'h80, 32'h0BAD_F00D);
    start = cur; dn_base = d_cnt[2];
    if_addr = 32'h80; if_req = 1'b1;
    repeat (3) tick();
    reset_n = 1'b0; if_req = 1'b0;
    tick();
    chk("t4_busy_after_rst", busy, 1'b0);
    reset_n = 1'b1;
    repeat (4) tick();
    chk("t4_no_done", d_cnt[2] - dn_base, 0);
    if_addr = 32'h40; if_req = 1'b1;
    drain(30);
    chk("t4_recover_done", d_cnt[2] - dn_base, 1);
    chk("t4_recover_rdata", d_rdata[2], 32'h6000_0000);

    // 5: display request dropped mid-transaction
    preload(32'h300, 32'h1234_5678);
    start = cur; en_base = en_cnt;
    ds_addr = 32'h300; ds_req = 1'b1;
    repeat (2) tick();
    ds_req = 1'b0;
    drain(30);
    chk("t5_done_cyc", d_cyc[3] - start, LAT + 2);
    chk("t5_one_mem_en", en_cnt - en_base, 1);
    chk("t5_rdata", d_rdata[3], 32'h1234_5678);

    // 6: idle
    en_base = en_cnt;
    act_base = g_cnt[1] + g_cnt[2] + g_cnt[3] + d_cnt[1] + d_cnt[2] + d_cnt[3];
    repeat (20) tick();
    chk("t6_no_mem_en", en_cnt - en_base, 0);
    chk("t6_no_activity", g_cnt[1] + g_cnt[2] + g_cnt[3] + d_cnt[1] + d_cnt[2] + d_cnt[3] - act_base, 0);

    // 7: random traffic, address/data churn while waiting, occasional early drops
    for (int c = 0; c < 400; c++) begin
      if (!dt_req && $urandom_range(0, 3) == 0) begin
        dt_req = 1'b1; dt_we = $urandom_range(0, 1) == 1;
        dt_addr = 32'h400 + 4 * $urandom_range(0, 15); dt_wdata = $urandom;
      end else if (dt_req && $urandom_range(0, 7) == 0) begin
        dt_we = $urandom_range(0, 1) == 1;
        dt_addr = 32'h400 + 4 * $urandom_range(0, 15); dt_wdata = $urandom;
      end
      if (!if_req && $urandom_range(0, 3) == 0) begin
        if_req = 1'b1; if_addr = 32'h400 + 4 * $urandom_range(0, 15);
      end else if (if_req && $urandom_range(0, 7) == 0) begin
        if_addr = 32'h400 + 4 * $urandom_range(0, 15);
      end
      if (!ds_req && $urandom_range(0, 3) == 0) begin
        ds_req = 1'b1; ds_addr = 32'h400 + 4 * $urandom_range(0, 15);
      end else if (ds_req && $urandom_range(0, 31) == 0) begin
        ds_req = 1'b0;
      end
      tick();
    end
    dt_req = 1'b0; if_req = 1'b0; ds_req = 1'b0;
    drain(20);
    for (int a = 0; a < 16; a++)
      chk("t7_mem_image",
          dev_mem.exists(32'h400 + 4 * a) ? dev_mem[32'h400 + 4 * a] : 32'h0,
          ref_mem.exists(32'h400 + 4 * a) ? ref_mem[32'h400 + 4 * a] : 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
